// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB completer with word-addressed register memory and wait states
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslave_error
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [3:0] WS_C = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_COMPLETE = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  err_in;
  logic                  latch;
  logic                  load;
  logic                  do_write;
  logic                  cur_err;
  logic                  cur_write;
  logic [IDX_W-1:0]      cur_idx;

  assign err_in = ({1'b0, paddr} >= DEPTH_C);

  // With zero wait states COMPLETE is entered on the setup edge itself, so the
  // transfer attributes come straight from the bus rather than the latches.
  assign cur_err   = (state == S_IDLE) ? err_in : err_q;
  assign cur_write = (state == S_IDLE) ? pwrite : write_q;
  assign cur_idx   = (state == S_IDLE) ? paddr[IDX_W-1:0] : idx_q;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    latch    = 1'b0;
    load     = 1'b0;
    do_write = 1'b0;
    case (state)
      S_IDLE: begin
        if (pselx && !penable) begin
          latch = 1'b1;
          if (WS_C == 4'd0) begin
            state_n = S_COMPLETE;
            load    = 1'b1;
          end else begin
            state_n = S_WAIT;
            cnt_n   = WS_C;
          end
        end
      end
      S_WAIT: begin
        if (!pselx) begin
          state_n = S_IDLE;
        end else if (penable) begin
          if (cnt <= 4'd1) begin
            state_n = S_COMPLETE;
            load    = 1'b1;
            cnt_n   = 4'd0;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
      end
      S_COMPLETE: begin
        state_n  = S_IDLE;
        do_write = pselx && penable && write_q && !err_q;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx_q        <= '0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      prdata       <= '0;
      pready       <= 1'b0;
      pslave_error <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      pready       <= load;
      pslave_error <= load && cur_err;
      if (latch) begin
        idx_q   <= paddr[IDX_W-1:0];
        write_q <= pwrite;
        err_q   <= err_in;
      end
      if (load && !cur_write) begin
        prdata <= cur_err ? '0 : mem[cur_idx];
      end
      if (do_write) begin
        mem[idx_q] <= pwdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb/tb_apb_mem_slave.sv - directed bench for apb_mem_slave with 0 and 2 wait states
module tb_apb_mem_slave;

  logic        clk;
  logic        presetn;
  logic [7:0]  paddr;
  logic        psel0, psel2;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata0, prdata2;
  logic        pready0, pready2;
  logic        err0, err2;

  int total  = 0;
  int passed = 0;

  apb_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(0)) dut0 (
    .pclk(clk), .presetn(presetn), .paddr(paddr), .pselx(psel0), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslave_error(err0)
  );

  apb_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(2)) dut2 (
    .pclk(clk), .presetn(presetn), .paddr(paddr), .pselx(psel2), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata2), .pready(pready2), .pslave_error(err2)
  );

  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Starts at #1 after an edge and returns at #1 after the completing edge,
  // so consecutive calls form back-to-back transfers with no idle cycle.
  task automatic xfer(input int which, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int cyc);
    bit done;
    done = 1'b0;
    rd   = 'x;
    er   = 1'bx;
    psel0 = (which == 0); psel2 = (which == 2);
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    cyc = 1;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      cyc++;
      if ((which == 0) ? pready0 : pready2) begin
        rd   = (which == 0) ? prdata0 : prdata2;
        er   = (which == 0) ? err0 : err2;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) $error("FAIL xfer_timeout observed=0x0 expected=0x1");
    psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          cyc;

  initial begin
    presetn = 1'b0;
    psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    #5 presetn = 1'b1;
    @(posedge clk); #1;

    check("rst_prdata", prdata0, 32'h0);
    check("rst_pready", {31'b0, pready0}, 32'h0);
    check("rst_err", {31'b0, err0}, 32'h0);
    check("rst_pready_ws2", {31'b0, pready2}, 32'h0);
    xfer(0, 1'b0, 8'h05, 32'h0, rd, er, cyc);
    check("rst_read05", rd, 32'h0);

    xfer(0, 1'b1, 8'h10, 32'hDEADBEEF, rd, er, cyc);
    check("wr10_err", {31'b0, er}, 32'h0);
    check("wr10_cycles", cyc, 2);
    xfer(0, 1'b0, 8'h10, 32'h0, rd, er, cyc);
    check("rd10_data", rd, 32'hDEADBEEF);
    check("rd10_err", {31'b0, er}, 32'h0);
    check("rd10_cycles", cyc, 2);
    @(posedge clk); #1;
    check("prdata_hold_idle", prdata0, 32'hDEADBEEF);
    xfer(0, 1'b1, 8'h20, 32'h00000011, rd, er, cyc);
    check("prdata_hold_write", prdata0, 32'hDEADBEEF);

    xfer(0, 1'b1, 8'h40, 32'h12345678, rd, er, cyc);
    check("wr40_err", {31'b0, er}, 32'h1);
    xfer(0, 1'b0, 8'h40, 32'h0, rd, er, cyc);
    check("rd40_err", {31'b0, er}, 32'h1);
    check("rd40_data", rd, 32'h0);
    xfer(0, 1'b0, 8'h00, 32'h0, rd, er, cyc);
    check("rd00_data", rd, 32'h0);
    check("rd00_err", {31'b0, er}, 32'h0);
    xfer(0, 1'b1, 8'h3F, 32'hCAFEF00D, rd, er, cyc);
    xfer(0, 1'b0, 8'h3F, 32'h0, rd, er, cyc);
    check("rd3f_data", rd, 32'hCAFEF00D);
    check("rd3f_err", {31'b0, er}, 32'h0);
    xfer(0, 1'b0, 8'hFF, 32'h0, rd, er, cyc);
    check("rdff_err", {31'b0, er}, 32'h1);

    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h10;
    @(posedge clk); #1;
    check("stray_penable_1", {31'b0, pready0}, 32'h0);
    @(posedge clk); #1;
    check("stray_penable_2", {31'b0, pready0}, 32'h0);
    psel0 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;

    xfer(2, 1'b1, 8'h03, 32'hA5A5A5A5, rd, er, cyc);
    check("ws2_wr_cycles", cyc, 4);
    xfer(2, 1'b0, 8'h03, 32'h0, rd, er, cyc);
    check("ws2_rd_data", rd, 32'hA5A5A5A5);
    check("ws2_rd_cycles", cyc, 4);
    check("ws2_rd_err", {31'b0, er}, 32'h0);

    for (int i = 1; i <= 3; i++) begin
      xfer(0, 1'b1, 8'(i), 32'(i), rd, er, cyc);
      check("b2b_wr_cycles", cyc, 2);
    end
    for (int i = 1; i <= 3; i++) begin
      xfer(0, 1'b0, 8'(i), 32'h0, rd, er, cyc);
      check("b2b_rd_data", rd, 32'(i));
      check("b2b_rd_cycles", cyc, 2);
    end

    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h07; pwdata = 32'h55;
    @(posedge clk); #1;
    penable = 1'b1;
    check("abort_wait_pready", {31'b0, pready2}, 32'h0);
    @(posedge clk); #1;
    psel2 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    check("abort_idle_pready", {31'b0, pready2}, 32'h0);
    xfer(2, 1'b0, 8'h07, 32'h0, rd, er, cyc);
    check("abort_rd07", rd, 32'h0);

    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h07; pwdata = 32'h77;
    @(posedge clk); #1;
    penable = 1'b1;
    check("midrst_complete", {31'b0, pready0}, 32'h1);
    presetn = 1'b0;
    #1;
    check("midrst_prdata", prdata0, 32'h0);
    check("midrst_pready", {31'b0, pready0}, 32'h0);
    check("midrst_err", {31'b0, err0}, 32'h0);
    #2 presetn = 1'b1;
    @(posedge clk); #1;
    check("midrst_after_pready", {31'b0, pready0}, 32'h0);
    psel0 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    xfer(0, 1'b0, 8'h07, 32'h0, rd, er, cyc);
    check("midrst_rd07", rd, 32'h0);
    xfer(0, 1'b0, 8'h10, 32'h0, rd, er, cyc);
    check("midrst_rd10_cleared", rd, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
